// File: rtl/delay_timer_mc_pkg.sv
// rtl/delay_timer_mc_pkg.sv - shared state encoding and default widths for the delay timer
package delay_timer_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 1;
    localparam int DEF_CNT_W  = 24;
    localparam int DEF_PW_W   = 8;

endpackage

// File: rtl/delay_timer_mc_if.sv
// rtl/delay_timer_mc_if.sv - per-channel trigger, config and output bundle of the delay timer
interface delay_timer_mc_if
    import delay_timer_mc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PW_W   = DEF_PW_W
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH*CNT_W-1:0] delay_val;
    logic [NUM_CH*PW_W-1:0]  pulse_len;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH-1:0]       retrig_en;
    logic [NUM_CH-1:0]       delay_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;

    modport master (
        output start, abort, delay_val, pulse_len, periodic, retrig_en,
        input  delay_out, busy, done
    );

    modport slave (
        input  start, abort, delay_val, pulse_len, periodic, retrig_en,
        output delay_out, busy, done
    );
endinterface

// File: rtl/delay_timer_mc_ch.sv
// rtl/delay_timer_mc_ch.sv - one timer channel: start edge detect, config shadow, FSM, delay and pulse counters
module delay_timer_mc_ch
    import delay_timer_mc_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PW_W  = DEF_PW_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_delay_val,
    input  logic [PW_W-1:0]  i_pulse_len,
    input  logic             i_periodic,
    input  logic             i_retrig_en,
    output logic             o_delay_out,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    logic             r_start_d;
    logic [CNT_W-1:0] r_cnt;
    logic [PW_W-1:0]  r_pcnt;
    logic [CNT_W-1:0] r_sh_d;
    logic [PW_W-1:0]  r_sh_p;
    logic             r_sh_per;
    logic             r_delay_out;
    logic             r_busy;
    logic             r_done;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [PW_W-1:0]  w_nxt_pcnt;
    logic             w_load_cfg;
    logic             w_start_edge;
    logic [CNT_W-1:0] w_d_eff;
    logic [PW_W-1:0]  w_p_eff;

    assign w_start_edge = i_start & ~r_start_d;
    // A zero delay or width would never hit the ==1 exit, so both are clamped to 1.
    assign w_d_eff = (i_delay_val == '0) ? CNT_W'(1) : i_delay_val;
    assign w_p_eff = (i_pulse_len == '0) ? PW_W'(1) : i_pulse_len;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_pcnt  = r_pcnt;
        w_load_cfg  = 1'b0;
        if (i_abort) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_pcnt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        w_load_cfg  = 1'b1;
                        w_nxt_state = ST_WAIT;
                        w_nxt_cnt   = w_d_eff;
                    end
                end
                ST_WAIT, ST_PULSE: begin
                    if (w_start_edge && i_retrig_en) begin
                        w_load_cfg  = 1'b1;
                        w_nxt_state = ST_WAIT;
                        w_nxt_cnt   = w_d_eff;
                    end else if (r_state == ST_WAIT) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_nxt_state = ST_PULSE;
                            w_nxt_pcnt  = r_sh_p;
                        end else begin
                            w_nxt_cnt = r_cnt - CNT_W'(1);
                        end
                    end else begin
                        if (r_pcnt == PW_W'(1)) begin
                            w_nxt_pcnt = '0;
                            if (r_sh_per) begin
                                w_nxt_state = ST_WAIT;
                                w_nxt_cnt   = r_sh_d;
                            end else begin
                                w_nxt_state = ST_IDLE;
                                w_nxt_cnt   = '0;
                            end
                        end else begin
                            w_nxt_pcnt = r_pcnt - PW_W'(1);
                        end
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_pcnt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b1;
            r_cnt       <= '0;
            r_pcnt      <= '0;
            r_sh_d      <= '0;
            r_sh_p      <= '0;
            r_sh_per    <= 1'b0;
            r_delay_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_start_d   <= i_start;
            r_cnt       <= w_nxt_cnt;
            r_pcnt      <= w_nxt_pcnt;
            if (w_load_cfg) begin
                r_sh_d   <= w_d_eff;
                r_sh_p   <= w_p_eff;
                r_sh_per <= i_periodic;
            end
            r_delay_out <= (w_nxt_state == ST_PULSE);
            r_busy      <= (w_nxt_state != ST_IDLE);
            r_done      <= (w_nxt_state == ST_PULSE) && (w_nxt_pcnt == PW_W'(1));
        end
    end

    assign o_delay_out = r_delay_out;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: rtl/delay_timer_mc.sv
// rtl/delay_timer_mc.sv - multi-channel one-shot/periodic delay timer; one independent channel per bit
module delay_timer_mc
    import delay_timer_mc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PW_W   = DEF_PW_W
) (
    input logic             clk,
    input logic             rst,
    delay_timer_mc_if.slave bus
);

    logic [NUM_CH-1:0] w_delay_out;
    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        delay_timer_mc_ch #(
            .CNT_W(CNT_W),
            .PW_W (PW_W)
        ) u_ch (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_start    (bus.start[g]),
            .i_abort    (bus.abort[g]),
            .i_delay_val(bus.delay_val[g*CNT_W +: CNT_W]),
            .i_pulse_len(bus.pulse_len[g*PW_W +: PW_W]),
            .i_periodic (bus.periodic[g]),
            .i_retrig_en(bus.retrig_en[g]),
            .o_delay_out(w_delay_out[g]),
            .o_busy     (w_busy[g]),
            .o_done     (w_done[g])
        );
    end

    assign bus.delay_out = w_delay_out;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule

// File: tb/tb_delay_timer_mc.sv
// tb/tb_delay_timer_mc.sv - scoreboard bench for delay_timer_mc with four channels
module tb_delay_timer_mc;

    localparam int NCH = 4;
    localparam int CW  = 24;
    localparam int PW  = 8;

    typedef struct {
        logic [NCH-1:0] dout;
        logic [NCH-1:0] busy;
        logic [NCH-1:0] done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    delay_timer_mc_if #(.NUM_CH(NCH), .CNT_W(CW), .PW_W(PW)) bus ();

    delay_timer_mc #(.NUM_CH(NCH), .CNT_W(CW), .PW_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected {delay_out, busy, done} j cycles after the accepting edge, using effective D/P.
    function automatic logic [2:0] exp_ch(int j, int d, int p, bit per);
        int m;
        if (j < 0) return 3'b000;
        if (per) begin
            m = j % (d + p);
            return {m >= d, 1'b1, m == d + p - 1};
        end
        return {(j >= d) && (j < d + p), j < d + p, j == d + p - 1};
    endfunction

    task automatic set_cfg(int c, int d, int p, bit per, bit rt);
        bus.delay_val[c*CW +: CW] = d[CW-1:0];
        bus.pulse_len[c*PW +: PW] = p[PW-1:0];
        bus.periodic[c]           = per;
        bus.retrig_en[c]          = rt;
    endtask

    task automatic fresh_start(logic [NCH-1:0] mask);
        bus.start = '0;
        @(negedge clk);
        bus.start = mask;
    endtask

    task automatic test_reset;
        exp_t e;
        set_cfg(0, 5, 3, 1'b0, 1'b0);
        bus.start = 4'b0001;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.delay_out, bus.busy, bus.done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %b exp 0", {bus.delay_out, bus.busy, bus.done});
        end
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            sb.push_back(e);
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL start_held_thru_reset j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
        end
        fresh_start(4'b0001);
        for (int j = 0; j < 10; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            {e.dout[0], e.busy[0], e.done[0]} = exp_ch(j, 5, 3, 1'b0);
            sb.push_back(e);
        end
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL oneshot_d5_p3 j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
        end
    endtask

    task automatic test_zero_cfg;
        exp_t e;
        set_cfg(0, 0, 0, 1'b0, 1'b0);
        fresh_start(4'b0001);
        for (int j = 0; j < 4; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            {e.dout[0], e.busy[0], e.done[0]} = exp_ch(j, 1, 1, 1'b0);
            sb.push_back(e);
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL zero_d_p j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
        end
    endtask

    task automatic test_periodic;
        exp_t e;
        set_cfg(0, 4, 2, 1'b1, 1'b0);
        fresh_start(4'b0001);
        for (int j = 0; j < 22; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            if (j < 20) {e.dout[0], e.busy[0], e.done[0]} = exp_ch(j, 4, 2, 1'b1);
            sb.push_back(e);
        end
        for (int j = 0; j < 22; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL periodic_d4_p2 j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
            if (j == 1)  bus.start[0] = 1'b0;
            if (j == 19) bus.abort[0] = 1'b1;
            if (j == 20) bus.abort[0] = 1'b0;
        end
    endtask

    task automatic test_retrigger(bit rt);
        exp_t e;
        set_cfg(0, 10, 2, 1'b0, rt);
        fresh_start(4'b0001);
        for (int j = 0; j < 20; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            if (!rt)        {e.dout[0], e.busy[0], e.done[0]} = exp_ch(j, 10, 2, 1'b0);
            else if (j < 6) {e.dout[0], e.busy[0], e.done[0]} = 3'b010;
            else            {e.dout[0], e.busy[0], e.done[0]} = exp_ch(j - 6, 10, 2, 1'b0);
            sb.push_back(e);
        end
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL retrigger_en%0d j=%0d got %b exp %b", rt, j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
            if (j == 2) bus.start[0] = 1'b0;
            if (j == 5) bus.start[0] = 1'b1;
        end
    endtask

    task automatic test_abort;
        exp_t e;
        set_cfg(0, 8, 2, 1'b0, 1'b1);
        fresh_start(4'b0001);
        for (int j = 0; j < 14; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            e.busy[0] = (j < 4);
            sb.push_back(e);
        end
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL abort_with_start j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
            if (j == 1) bus.start[0] = 1'b0;
            if (j == 3) begin bus.abort[0] = 1'b1; bus.start[0] = 1'b1; end
            if (j == 4) bus.abort[0] = 1'b0;
        end
    endtask

    task automatic test_multi_channel;
        exp_t e;
        int dv[NCH] = '{3, 7, 1, 12};
        for (int c = 0; c < NCH; c++) set_cfg(c, dv[c], 2, 1'b0, 1'b0);
        fresh_start(4'b1111);
        for (int j = 0; j < 16; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            for (int c = 0; c < NCH; c++)
                {e.dout[c], e.busy[c], e.done[c]} = exp_ch(j, dv[c], 2, 1'b0);
            sb.push_back(e);
        end
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL multi_ch j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
            if (j == 1) begin
                bus.start = '0;
                for (int c = 0; c < NCH; c++) set_cfg(c, 20, 5, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        int dv[NCH] = '{3, 7, 1, 12};
        for (int c = 0; c < NCH; c++) set_cfg(c, dv[c], 4, 1'b0, 1'b0);
        fresh_start(4'b1111);
        for (int j = 0; j < 14; j++) begin
            e.dout = '0; e.busy = '0; e.done = '0;
            for (int c = 0; c < NCH; c++)
                {e.dout[c], e.busy[c], e.done[c]} = exp_ch(j, dv[c], 4, 1'b0);
            sb.push_back(e);
        end
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.delay_out, bus.busy, bus.done} !== {e.dout, e.busy, e.done}) begin
                errors++;
                $display("FAIL pre_reset_run j=%0d got %b exp %b", j,
                         {bus.delay_out, bus.busy, bus.done}, {e.dout, e.busy, e.done});
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.delay_out, bus.busy, bus.done} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset_mid_pulse got %b exp 0", {bus.delay_out, bus.busy, bus.done});
        end
        bus.start = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.delay_out, bus.busy, bus.done} !== 12'h000) begin
            errors++;
            $display("FAIL after_reset_idle got %b exp 0", {bus.delay_out, bus.busy, bus.done});
        end
    endtask

    initial begin
        bus.start = '0;
        bus.abort = '0;
        bus.delay_val = '0;
        bus.pulse_len = '0;
        bus.periodic = '0;
        bus.retrig_en = '0;
        test_reset();
        test_zero_cfg();
        test_periodic();
        test_retrigger(1'b1);
        test_retrigger(1'b0);
        test_abort();
        test_multi_channel();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
